// File: rtl/spi_target_if_if.sv
// ----------------------------------------------------------------------------
// spi_target_if_if
// Bundles the SPI pin signals and the user-side byte handshake of the SPI
// target block.
//   slave  modport : seen by spi_target_if (pins in, miso out, user bytes out)
//   master modport : seen by whatever drives the pins and consumes the bytes
// Signals:
//   cs_n, sclk, mosi          SPI pins from the external master
//   miso, miso_oe             SPI data out and its pad enable
//   data_tx, tx_ack           next transmit byte and its latch pulse
//   data_rx, rx_valid         last received byte and its update pulse
//   frame_active, frame_end   frame status
//   byte_cnt                  bytes received in the current frame
// ----------------------------------------------------------------------------
interface spi_target_if_if;
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] data_tx;
    logic       tx_ack;
    logic [7:0] data_rx;
    logic       rx_valid;
    logic       frame_active;
    logic       frame_end;
    logic [7:0] byte_cnt;

    modport slave (
        input  cs_n, sclk, mosi, data_tx,
        output miso, miso_oe, tx_ack, data_rx, rx_valid,
               frame_active, frame_end, byte_cnt
    );

    modport master (
        output cs_n, sclk, mosi, data_tx,
        input  miso, miso_oe, tx_ack, data_rx, rx_valid,
               frame_active, frame_end, byte_cnt
    );
endinterface

// File: rtl/spi_target_if.sv
// ----------------------------------------------------------------------------
// spi_target_if
// SPI target that oversamples cs_n/sclk/mosi with sys_clk, assembles 8-bit
// receive words (MSB first) and shifts a transmit word out on miso in full
// duplex. A frame is one cs_n low period carrying any number of bytes.
// Parameters:
//   CPOL  sclk idle level
//   CPHA  0: sample on leading edge, drive on trailing edge
//         1: drive on leading edge, sample on trailing edge
// Ports:
//   sys_clk    system clock
//   sys_rst_n  asynchronous active-low reset
//   bus        spi_target_if_if.slave (pins + user byte handshake)
// ----------------------------------------------------------------------------
module spi_target_if #(
    parameter logic CPOL = 1'b1,
    parameter logic CPHA = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    spi_target_if_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_END   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers: [0],[1] are the 2-FF synchronizer, [2] is the
    // extra stage used for edge detection.
    // cs_n and sclk reset to their inactive levels so that leaving reset
    // never fabricates a frame start or an sclk edge.
    // ------------------------------------------------------------------
    logic [2:0] r_cs_sync;
    logic [2:0] r_sclk_sync;
    logic [2:0] r_mosi_sync;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cs_sync   <= 3'b111;
            r_sclk_sync <= {3{CPOL}};
            r_mosi_sync <= 3'b000;
        end else begin
            r_cs_sync   <= {r_cs_sync[1:0],   bus.cs_n};
            r_sclk_sync <= {r_sclk_sync[1:0], bus.sclk};
            r_mosi_sync <= {r_mosi_sync[1:0], bus.mosi};
        end
    end

    logic w_lead;
    logic w_trail;
    logic w_cs_fall;
    logic w_cs_rise;

    assign w_lead    = (r_sclk_sync[1] != CPOL) && (r_sclk_sync[2] == CPOL);
    assign w_trail   = (r_sclk_sync[1] == CPOL) && (r_sclk_sync[2] != CPOL);
    assign w_cs_fall = !r_cs_sync[1] &&  r_cs_sync[2];
    assign w_cs_rise =  r_cs_sync[1] && !r_cs_sync[2];

    // Registered edge strobes: three cycles after the pin edge.
    logic r_lead;
    logic r_trail;
    logic r_cs_fall;
    logic r_cs_rise;
    logic r_frame_active;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_lead         <= 1'b0;
            r_trail        <= 1'b0;
            r_cs_fall      <= 1'b0;
            r_cs_rise      <= 1'b0;
            r_frame_active <= 1'b0;
        end else begin
            r_lead         <= w_lead;
            r_trail        <= w_trail;
            r_cs_fall      <= w_cs_fall;
            r_cs_rise      <= w_cs_rise;
            r_frame_active <= !r_cs_sync[1];
        end
    end

    // r_mosi_sync[2] lines up with the strobe: it holds the mosi value that
    // was synchronized together with the sclk edge being acted on.
    logic w_mosi_s;
    logic w_sample;
    logic w_drive;

    assign w_mosi_s = r_mosi_sync[2];
    assign w_sample = CPHA ? r_trail : r_lead;
    assign w_drive  = CPHA ? r_lead  : r_trail;

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_start;
    logic   w_proc;
    logic   w_go_end;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_proc      = 1'b0;
        w_go_end    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_cs_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Edges are still processed in the cycle cs rises, so a
                // byte completed by that last sample is not lost.
                w_proc = 1'b1;
                if (r_cs_rise) begin
                    w_go_end    = 1'b1;
                    w_state_nxt = S_END;
                end
            end
            S_END:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [7:0] r_tx_sh;
    logic [7:0] r_rx_sh;
    logic [2:0] r_bit_cnt;
    logic       r_byte_done;
    logic [7:0] r_data_rx;
    logic       r_rx_valid;
    logic       r_tx_ack;
    logic [7:0] r_byte_cnt;
    logic       r_frame_end;
    logic       r_miso;
    logic       r_miso_oe;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tx_sh     <= 8'h00;
            r_rx_sh     <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_byte_done <= 1'b0;
            r_data_rx   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_ack    <= 1'b0;
            r_byte_cnt  <= 8'h00;
            r_frame_end <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_tx_ack    <= 1'b0;
            r_frame_end <= 1'b0;

            if (w_start) begin
                r_tx_sh     <= bus.data_tx;
                r_tx_ack    <= 1'b1;
                r_bit_cnt   <= 3'd0;
                r_byte_cnt  <= 8'h00;
                r_byte_done <= 1'b0;
                r_rx_sh     <= 8'h00;
                r_miso_oe   <= 1'b1;
                // CPHA=0 has no drive edge before the first sample, so the
                // first bit goes out straight from the frame start.
                r_miso      <= CPHA ? 1'b0 : bus.data_tx[7];
            end

            if (w_proc) begin
                if (w_sample) begin
                    r_rx_sh   <= {r_rx_sh[6:0], w_mosi_s};
                    r_bit_cnt <= r_bit_cnt + 3'd1;   // wraps to 0 after bit 8
                    if (r_bit_cnt == 3'd7) begin
                        r_data_rx  <= {r_rx_sh[6:0], w_mosi_s};
                        r_rx_valid <= 1'b1;
                        r_byte_cnt <= r_byte_cnt + 8'd1;
                        if (CPHA) begin
                            // Next byte is needed at the very next lead edge.
                            r_tx_sh  <= bus.data_tx;
                            r_tx_ack <= 1'b1;
                        end else begin
                            r_byte_done <= 1'b1;
                        end
                    end
                end

                if (w_drive) begin
                    if (!CPHA) begin
                        if (r_byte_done) begin
                            r_tx_sh     <= bus.data_tx;
                            r_miso      <= bus.data_tx[7];
                            r_tx_ack    <= 1'b1;
                            r_byte_done <= 1'b0;
                        end else begin
                            r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                            r_miso  <= r_tx_sh[6];
                        end
                    end else begin
                        if (r_bit_cnt == 3'd0) begin
                            r_miso <= r_tx_sh[7];
                        end else begin
                            r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                            r_miso  <= r_tx_sh[6];
                        end
                    end
                end

                if (w_go_end) begin
                    r_frame_end <= 1'b1;
                    r_miso_oe   <= 1'b0;
                    r_miso      <= 1'b0;
                end
            end
        end
    end

    assign bus.miso         = r_miso & r_miso_oe;
    assign bus.miso_oe      = r_miso_oe;
    assign bus.tx_ack       = r_tx_ack;
    assign bus.data_rx      = r_data_rx;
    assign bus.rx_valid     = r_rx_valid;
    assign bus.frame_active = r_frame_active;
    assign bus.frame_end    = r_frame_end;
    assign bus.byte_cnt     = r_byte_cnt;

endmodule

// File: tb/tb_spi_target_if.sv
// ----------------------------------------------------------------------------
// tb_spi_target_if
// Two targets: u_dut3 (CPOL=1,CPHA=1) and u_dut0 (CPOL=0,CPHA=0) share the
// master pins; sel routes cs_n to one of them and selects its outputs.
// Expected received bytes go into exp_rx; a monitor thread pops and compares
// on every rx_valid.
// ----------------------------------------------------------------------------
module tb_spi_target_if;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       cpol = 1'b1;
    logic       cpha = 1'b1;
    logic       cs_n = 1'b1;
    logic       sclk = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] data_tx = 8'h00;
    int         hp = 8;

    always #5 clk = ~clk;

    spi_target_if_if b3 ();
    spi_target_if_if b0 ();

    assign b3.cs_n    = sel ? 1'b1 : cs_n;
    assign b3.sclk    = sclk;
    assign b3.mosi    = mosi;
    assign b3.data_tx = data_tx;
    assign b0.cs_n    = sel ? cs_n : 1'b1;
    assign b0.sclk    = sclk;
    assign b0.mosi    = mosi;
    assign b0.data_tx = data_tx;

    spi_target_if #(.CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(b3));
    spi_target_if #(.CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(b0));

    logic       m_miso, m_miso_oe, m_tx_ack, m_rx_valid, m_frame_active, m_frame_end;
    logic [7:0] m_data_rx, m_byte_cnt;
    assign m_miso         = sel ? b0.miso         : b3.miso;
    assign m_miso_oe      = sel ? b0.miso_oe      : b3.miso_oe;
    assign m_tx_ack       = sel ? b0.tx_ack       : b3.tx_ack;
    assign m_rx_valid     = sel ? b0.rx_valid     : b3.rx_valid;
    assign m_frame_active = sel ? b0.frame_active : b3.frame_active;
    assign m_frame_end    = sel ? b0.frame_end    : b3.frame_end;
    assign m_data_rx      = sel ? b0.data_rx      : b3.data_rx;
    assign m_byte_cnt     = sel ? b0.byte_cnt     : b3.byte_cnt;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         n_rx = 0, n_ack = 0, n_fe = 0;
    int         rx_cyc = 0, t_samp = 0;
    logic [7:0] exp_rx[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (m_rx_valid) begin
                n_rx++;
                rx_cyc = cyc;
                total++;
                if (exp_rx.size() == 0) begin
                    bad++;
                    $display("FAIL rx_unexpected: got %02h expected no byte", m_data_rx);
                end else begin
                    e = exp_rx.pop_front();
                    if (m_data_rx !== e) begin
                        bad++;
                        $display("FAIL rx_data: got %02h expected %02h", m_data_rx, e);
                    end
                end
            end
            if (m_tx_ack)    n_ack++;
            if (m_frame_end) n_fe++;
        end
    endtask

    task automatic set_mode(input logic s);
        @(negedge clk);
        sel  = s;
        cpol = ~s;
        cpha = ~s;
        sclk = ~s;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (hp) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // One byte (or its first nbits) from the master, capturing miso.
    task automatic xbyte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cpha) begin
                mosi = tx[i];
                repeat (hp) @(negedge clk);
                rx[i] = m_miso;
                sclk = ~cpol;
                t_samp = cyc;
                repeat (hp) @(negedge clk);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = tx[i];
                repeat (hp) @(negedge clk);
                rx[i] = m_miso;
                sclk = cpol;
                t_samp = cyc;
                repeat (hp) @(negedge clk);
            end
        end
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (m_tx_ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] r0, r1, r2;
        logic [7:0] nxt [3];
        int         a_rx, a_ack, a_fe;
        bit         ok;
        nxt[0] = 8'h22; nxt[1] = 8'h33; nxt[2] = 8'h44;

        fork
            forever begin @(posedge clk); cyc++; end
            monitor();
        join_none

        // ---------------- reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_miso_oe", {b3.miso_oe, b0.miso_oe}, 0);
        chk("rst_miso", {b3.miso, b0.miso}, 0);
        chk("rst_frame_active", {b3.frame_active, b0.frame_active}, 0);
        chk("rst_pulses", {b3.rx_valid, b3.tx_ack, b3.frame_end, b0.rx_valid, b0.tx_ack, b0.frame_end}, 0);
        chk("rst_data_rx", {b3.data_rx, b0.data_rx}, 0);
        chk("rst_byte_cnt", {b3.byte_cnt, b0.byte_cnt}, 0);

        // ---------------- single byte, CPOL=1 CPHA=1
        hp = 8;
        data_tx = 8'h3C;
        a_rx = n_rx; a_ack = n_ack; a_fe = n_fe;
        exp_rx.push_back(8'hA5);
        cs_low();
        chk("t1_frame_active", m_frame_active, 1);
        chk("t1_miso_oe", m_miso_oe, 1);
        xbyte(8'hA5, 8, r0);
        chk("t1_rx_latency", rx_cyc - t_samp, 4);
        cs_high();
        chk("t1_master_rd", r0, 8'h3C);
        chk("t1_rx_count", n_rx - a_rx, 1);
        chk("t1_byte_cnt", m_byte_cnt, 1);
        chk("t1_frame_end", n_fe - a_fe, 1);
        chk("t1_tx_ack", n_ack - a_ack, 2);
        chk("t1_idle_oe", {m_miso_oe, m_miso, m_frame_active}, 0);

        // ---------------- burst, CPOL=0 CPHA=0
        set_mode(1'b1);
        data_tx = 8'h11;
        a_rx = n_rx; a_ack = n_ack; a_fe = n_fe;
        exp_rx.push_back(8'h01); exp_rx.push_back(8'h80); exp_rx.push_back(8'hFF);
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_ack(ok);
                    chk("t2_ack_seen", ok, 1);
                    data_tx = nxt[k];
                end
            end
            begin
                cs_low();
                xbyte(8'h01, 8, r0);
                xbyte(8'h80, 8, r1);
                xbyte(8'hFF, 8, r2);
                cs_high();
            end
        join
        chk("t2_master_rd0", r0, 8'h11);
        chk("t2_master_rd1", r1, 8'h22);
        chk("t2_master_rd2", r2, 8'h33);
        chk("t2_rx_count", n_rx - a_rx, 3);
        chk("t2_byte_cnt", m_byte_cnt, 3);
        chk("t2_tx_ack", n_ack - a_ack, 4);
        chk("t2_frame_end", n_fe - a_fe, 1);

        // ---------------- mid-byte abort, then a clean frame
        a_rx = n_rx; a_fe = n_fe;
        cs_low();
        xbyte(8'hC3, 5, r0);
        cs_high();
        chk("t3_no_rx", n_rx - a_rx, 0);
        chk("t3_data_rx_held", m_data_rx, 8'hFF);
        chk("t3_frame_end", n_fe - a_fe, 1);
        chk("t3_miso_oe", {m_miso_oe, m_miso}, 0);
        chk("t3_byte_cnt", m_byte_cnt, 0);
        data_tx = 8'h77;
        exp_rx.push_back(8'h5A);
        cs_low();
        xbyte(8'h5A, 8, r0);
        cs_high();
        chk("t3_next_rx_count", n_rx - a_rx, 1);
        chk("t3_next_master_rd", r0, 8'h77);
        chk("t3_next_byte_cnt", m_byte_cnt, 1);

        // ---------------- spurious sclk with cs_n high
        a_rx = n_rx; a_ack = n_ack;
        for (int k = 0; k < 16; k++) begin
            sclk = ~sclk;
            mosi = k[0];
            repeat (4) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        chk("t4_no_rx", n_rx - a_rx, 0);
        chk("t4_no_ack", n_ack - a_ack, 0);
        chk("t4_miso_oe", m_miso_oe, 0);
        chk("t4_byte_cnt", m_byte_cnt, 1);

        // ---------------- async reset mid-frame, CPOL=1 CPHA=1
        set_mode(1'b0);
        data_tx = 8'h0F;
        cs_low();
        xbyte(8'hFF, 3, r0);
        chk("t5_pre_oe", m_miso_oe, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_oe", {m_miso_oe, m_miso}, 0);
        chk("t5_rst_frame_active", m_frame_active, 0);
        chk("t5_rst_data_rx", m_data_rx, 0);
        chk("t5_rst_byte_cnt", m_byte_cnt, 0);
        cs_n = 1'b1;
        sclk = cpol;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        a_rx = n_rx;
        data_tx = 8'h69;
        exp_rx.push_back(8'h96);
        cs_low();
        xbyte(8'h96, 8, r0);
        cs_high();
        chk("t5_rx_count", n_rx - a_rx, 1);
        chk("t5_master_rd", r0, 8'h69);
        chk("t5_byte_cnt", m_byte_cnt, 1);

        // ---------------- 257-byte frame, byte_cnt wraps
        hp = 6;
        a_rx = n_rx;
        for (int k = 0; k < 257; k++) exp_rx.push_back(8'(k));
        cs_low();
        for (int k = 0; k < 257; k++) xbyte(8'(k), 8, r0);
        cs_high();
        chk("t6_rx_count", n_rx - a_rx, 257);
        chk("t6_byte_cnt", m_byte_cnt, 1);
        chk("t6_exp_drained", exp_rx.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
